// File: rtl/synth_pkg.sv
// Shared types and helpers for the audio output path.
// The sample type tracks the default sample width; the I2S transmitter below is itself parameterised.
package synth_pkg;

  localparam int unsigned SAMPLE_W_DEF = 24;

  typedef logic signed [SAMPLE_W_DEF-1:0] sample_t;

  typedef enum logic {
    IDLE,
    SHIFT
  } i2s_state_e;

  // clk cycles per bclk half-period (integer division)
  function automatic int unsigned half_cycles(input int unsigned clk_freq,
                                              input int unsigned fs,
                                              input int unsigned slot_w);
    return clk_freq / (fs * 4 * slot_w);
  endfunction

endpackage

// File: rtl/i2s_bit_timer.sv
// Half-period down-counter that generates the gated I2S bit clock.
// bit_end and rise flag the cycle just before bclk falls and rises, respectively.
module i2s_bit_timer #(
  parameter int unsigned HALF = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic bclk,
  output logic bit_end,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(HALF + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bclk_q, bclk_d;
  logic             tc;

  assign tc = run && (cnt_q == '0);

  always_comb begin
    cnt_d  = cnt_q;
    bclk_d = bclk_q;
    if (start) begin
      cnt_d  = CNT_LOAD;
      bclk_d = 1'b0;
    end else if (tc) begin
      cnt_d  = CNT_LOAD;
      bclk_d = ~bclk_q;
    end else if (run) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= CNT_LOAD;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk    = bclk_q;
  assign bit_end = tc & bclk_q;
  assign rise    = tc & ~bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: latches one stereo pair per tick and shifts it out as a
// standard I2S frame (MSB first, one-bit delay) under a gated bit clock.
module i2s_tx
  import synth_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned FS       = 48000,
  parameter int unsigned SAMPLE_W = 24,
  parameter int unsigned SLOT_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic signed [SAMPLE_W-1:0] sample_l,
  input  logic signed [SAMPLE_W-1:0] sample_r,
  output logic                       sample_ack,
  output logic                       bclk,
  output logic                       lrclk,
  output logic                       sdata,
  output logic                       busy,
  output logic                       overrun
);

  localparam int unsigned HALF    = half_cycles(CLK_FREQ, FS, SLOT_W);
  localparam int unsigned FRAME_W = 2 * SLOT_W;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);
  localparam int unsigned PAD_W   = SLOT_W - SAMPLE_W - 1;
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] SLOT_LAST = BIT_W'(SLOT_W - 1);

  if (HALF < 1) begin : g_bad_half
    $error("i2s_tx: CLK_FREQ too low for FS and SLOT_W (HALF < 1)");
  end
  if (SLOT_W < SAMPLE_W + 1) begin : g_bad_slot
    $error("i2s_tx: SLOT_W must be at least SAMPLE_W + 1");
  end

  i2s_state_e         state_q, state_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] image_q, image_d;
  logic               ack_q, ack_d;
  logic               lrclk_q, lrclk_d;
  logic               sdata_q, sdata_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;

  logic               frame_start;
  logic               bit_end;
  logic               bclk_rise;
  logic [SLOT_W-1:0]  slot_l, slot_r;

  // Slot layout, MSB transmitted first: delay bit, sample, zero padding.
  assign slot_l = SLOT_W'({1'b0, sample_l}) << PAD_W;
  assign slot_r = SLOT_W'({1'b0, sample_r}) << PAD_W;

  i2s_bit_timer #(
    .HALF(HALF)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (frame_start),
    .run    (state_q == SHIFT),
    .bclk   (bclk),
    .bit_end(bit_end),
    .rise   (bclk_rise)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    image_d     = image_q;
    ack_d       = 1'b0;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
    frame_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d     = SHIFT;
          frame_start = 1'b1;
          image_d     = {slot_l, slot_r};
          bit_cnt_d   = '0;
          ack_d       = 1'b1;
          busy_d      = 1'b1;
          lrclk_d     = 1'b0;
          sdata_d     = 1'b0;
        end
      end
      SHIFT: begin
        // A tick mid-frame, including the final cycle, is dropped and latched as overrun.
        if (tick) overrun_d = 1'b1;
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            lrclk_d = 1'b0;
            sdata_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            image_d   = image_q << 1;
            sdata_d   = image_q[FRAME_W-2];
            if (bit_cnt_q == SLOT_LAST) lrclk_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      image_q   <= '0;
      ack_q     <= 1'b0;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      image_q   <= image_d;
      ack_q     <= ack_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  // The timer may only announce a rising edge from the low phase of an active frame.
  a_rise_in_frame: assert property (@(posedge clk) disable iff (rst)
    bclk_rise |-> (state_q == SHIFT && !bclk));

  assign sample_ack = ack_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: expected frame images are queued at each accepted
// tick and compared against the bits captured on bclk rising edges.
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [23:0] sample_l, sample_r;
  logic        sample_ack, bclk, lrclk, sdata, busy, overrun;

  i2s_tx dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .sample_l  (sample_l),
    .sample_r  (sample_r),
    .sample_ack(sample_ack),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .sdata     (sdata),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] sb_data[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] frame_img(input logic [23:0] l, input logic [23:0] r);
    logic [63:0] v;
    logic [23:0] s;
    int j;
    v = '0;
    for (int k = 0; k < 64; k++) begin
      j = k % 32;
      s = (k < 32) ? l : r;
      if (j >= 1 && j <= 24) v[63-k] = s[24-j];
    end
    return v;
  endfunction

  // monitor state
  int          ack_cnt = 0;
  int          bitn = 0;
  int          hi_run = 0, busy_run = 0;
  int          last_hi = 0, last_per = 0, last_rise = 0, first_rise = 0;
  int          per_err = 0, duty_err = 0;
  logic        busy_prev = 1'b0, bclk_prev = 1'b0;
  logic        aborting = 1'b0;
  logic [63:0] cap_d = '0, cap_lr = '0;

  always @(negedge clk) begin
    if (sample_ack) ack_cnt++;
    if (rst) begin
      bitn = 0;
      hi_run = 0;
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      else if (busy_prev) begin
        if (!aborting) check("busy_len", 64'(busy_run), 64'd2048);
        busy_run = 0;
      end
      if (bclk) hi_run++;
      else if (bclk_prev) begin
        last_hi = hi_run;
        if (!aborting && hi_run != 16) duty_err++;
        hi_run = 0;
      end
      if (bclk && !bclk_prev) begin
        if (bitn == 0) first_rise = cyc;
        else begin
          last_per = cyc - last_rise;
          if (last_per != 32) per_err++;
        end
        last_rise = cyc;
        cap_d  = {cap_d[62:0], sdata};
        cap_lr = {cap_lr[62:0], lrclk};
        bitn++;
        if (bitn == 64) begin
          check("sb_has_frame", 64'(sb_data.size() != 0), 64'd1);
          if (sb_data.size() != 0) begin
            check("frame_data", cap_d, sb_data.pop_front());
            check("frame_lrclk", cap_lr, 64'h00000000_FFFFFFFF);
          end
          bitn = 0;
        end
      end
    end
    busy_prev = busy;
    bclk_prev = bclk;
  end

  int t_tick = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; leaves the bench at the following posedge+1.
  task automatic tick_now(input logic [23:0] l, input logic [23:0] r, input bit accept);
    sample_l = l;
    sample_r = r;
    tick = 1'b1;
    if (accept) begin
      t_tick = cyc;
      sb_data.push_back(frame_img(l, r));
    end
    step(1);
    tick = 1'b0;
    sample_l = 24'($urandom);
    sample_r = 24'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_data.size() != 0 || busy) && n < 5000) begin
      step(1);
      n++;
    end
    check("wait_idle_timeout", 64'(n >= 5000), 64'd0);
  endtask

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] act;
    int ack0, rem, per, n, t_clean;

    rst = 1'b1;
    tick = 1'b0;
    sample_l = '0;
    sample_r = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outs", 64'({sample_ack, bclk, lrclk, sdata, busy, overrun}), 64'd0);
    act = '0;
    repeat (100) begin
      @(negedge clk);
      act |= {sample_ack, bclk, lrclk, sdata, busy, overrun};
    end
    check("idle_activity", 64'(act), 64'd0);
    step(1);

    // directed frame
    ack0 = ack_cnt;
    tick_now(24'h800001, 24'h7FFFFE, 1'b1);
    @(negedge clk);
    check("ack_t1", 64'(sample_ack), 64'd1);
    check("busy_t1", 64'(busy), 64'd1);
    check("start_outs", 64'({bclk, lrclk, sdata}), 64'd0);
    step(1);
    @(negedge clk);
    check("ack_width", 64'(sample_ack), 64'd0);
    step(1);
    wait_idle();
    check("rise_latency", 64'(first_rise - t_tick), 64'd17);
    check("bclk_period", 64'(last_per), 64'd32);
    check("bclk_high", 64'(last_hi), 64'd16);
    check("ack_count_t1", 64'(ack_cnt - ack0), 64'd1);

    // 48 kHz tick cadence from a 100 MHz clock
    ack0 = ack_cnt;
    rem = 0;
    for (int f = 0; f < 10; f++) begin
      tick_now(24'($urandom), 24'($urandom), 1'b1);
      per = 100000000 / 48000;
      rem += 100000000 % 48000;
      if (rem >= 48000) begin
        rem -= 48000;
        per++;
      end
      step(per - 1);
    end
    wait_idle();
    check("overrun_real", 64'(overrun), 64'd0);
    check("ack_count_real", 64'(ack_cnt - ack0), 64'd10);

    // tick 1000 cycles into a frame
    ack0 = ack_cnt;
    tick_now(24'h123456, 24'hFEDCBA, 1'b1);
    step(999);
    tick_now(24'h0F0F0F, 24'hA5A5A5, 1'b0);
    @(negedge clk);
    check("overrun_set", 64'(overrun), 64'd1);
    check("ack_on_overrun", 64'(sample_ack), 64'd0);
    step(1);
    wait_idle();
    check("overrun_sticky", 64'(overrun), 64'd1);
    check("ack_count_ovr", 64'(ack_cnt - ack0), 64'd1);

    // reset during bit 40
    tick_now(24'h55AA55, 24'hAA55AA, 1'b1);
    n = 0;
    while (bitn < 41 && n < 3000) begin
      step(1);
      n++;
    end
    check("bit40_timeout", 64'(n >= 3000), 64'd0);
    aborting = 1'b1;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check("reset_mid_outs", 64'({sample_ack, bclk, lrclk, sdata, busy, overrun}), 64'd0);
    void'(sb_data.pop_back());
    step(5);
    aborting = 1'b0;

    // clean frame, then a tick in its final busy cycle
    tick_now(24'h400000, 24'hC00001, 1'b1);
    t_clean = t_tick;
    while (cyc < t_clean + 2048) step(1);
    ack0 = ack_cnt;
    tick_now(24'h111111, 24'h222222, 1'b0);
    @(negedge clk);
    check("busy_after_last", 64'(busy), 64'd0);
    check("overrun_last_cycle", 64'(overrun), 64'd1);
    check("ack_last_cycle", 64'(sample_ack), 64'd0);
    step(1);
    wait_idle();
    tick_now(24'h7FFFFF, 24'h000001, 1'b1);
    wait_idle();
    check("ack_count_after", 64'(ack_cnt - ack0), 64'd1);

    check("bclk_period_errs", 64'(per_err), 64'd0);
    check("bclk_duty_errs", 64'(duty_err), 64'd0);
    check("sb_leftover", 64'(sb_data.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
